matmul_sequencer: RTL and testbench

//  Sequences one matrix-multiply run from the fields of the 16-bit control register: start, mode, N/K/M, read/write targets.

---
 rtl/matmul_sequencer_if.sv | 27 ++
 rtl/matmul_sequencer.sv | 128 ++++++++++++
 tb/tb_matmul_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/matmul_sequencer_if.sv
// Sequencer-side bus to the PE array (operand beats, clear, held M) and the shared
// scratchpad port (request/grant, address, bias capture, row select).
interface matmul_sequencer_if #(
  parameter int DIM_WIDTH = 2,
  parameter int SP_AW     = 4
);
  logic                 op_valid;
  logic                 op_ready;
  logic [DIM_WIDTH-1:0] op_k;
  logic                 pe_clear;
  logic [DIM_WIDTH-1:0] m_dim;
  logic                 sp_req;
  logic                 sp_gnt;
  logic                 sp_we;
  logic [SP_AW-1:0]     sp_addr;
  logic                 bias_load;
  logic [DIM_WIDTH-1:0] row_sel;

  modport master (
    output op_valid, op_k, pe_clear, m_dim, sp_req, sp_we, sp_addr, bias_load, row_sel,
    input  op_ready, sp_gnt
  );
  modport slave (
    input  op_valid, op_k, pe_clear, m_dim, sp_req, sp_we, sp_addr, bias_load, row_sel,
    output op_ready, sp_gnt
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Runs one matmul: K operand beats, PE drain, optional bias-row reads, N result-row writes.
// Define MATMUL_SEQ_CYCLE_CNT_EN to add the saturating cycles_o run-length counter.
module matmul_sequencer #(
  parameter int PE_LATENCY = 2,
  parameter int DIM_WIDTH  = 2,
  parameter int SP_AW      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_bit_i,
  input  logic                 mode_bit_i,
  input  logic [1:0]           write_target_i,
  input  logic [1:0]           read_target_i,
  input  logic [DIM_WIDTH-1:0] n_dim_i,
  input  logic [DIM_WIDTH-1:0] k_dim_i,
  input  logic [DIM_WIDTH-1:0] m_dim_i,
  output logic                 start_clear_o,
  output logic                 busy_o,
  output logic                 done_o,
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  output logic [15:0]          cycles_o,
`endif
  matmul_sequencer_if.master   bus
);
  localparam int DCW = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PE_LATENCY - 1);
  localparam logic [DIM_WIDTH-1:0] ROW0 = '0;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_BIAS, S_WRITE, S_DONE} state_t;

  state_t               state;
  logic                 mode_q;
  logic [1:0]           wt_q, rt_q;
  logic [DIM_WIDTH-1:0] n_q, k_q, m_q, row_q, row_nx, op_k_q, row_sel_q;
  logic [DCW-1:0]       drain_cnt;
  logic                 busy_q, done_q, op_valid_q, sp_req_q, sp_we_q, bias_load_q;
  logic [SP_AW-1:0]     sp_addr_q;
  logic                 accept;

  // The accept pulses are combinational so the control register clears in the same cycle it is seen.
  assign accept        = (state == S_IDLE) && start_bit_i && !rst_i;
  assign start_clear_o = accept;
  assign bus.pe_clear  = accept;
  assign row_nx        = row_q + DIM_WIDTH'(1);

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.op_k      = op_k_q;
  assign bus.m_dim     = m_q;
  assign bus.sp_req    = sp_req_q;
  assign bus.sp_we     = sp_we_q;
  assign bus.sp_addr   = sp_addr_q;
  assign bus.bias_load = bias_load_q;
  assign bus.row_sel   = row_sel_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      mode_q <= 1'b0; wt_q <= '0; rt_q <= '0; n_q <= '0; k_q <= '0; m_q <= '0;
      row_q <= '0; op_k_q <= '0; row_sel_q <= '0; drain_cnt <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; op_valid_q <= 1'b0;
      sp_req_q <= 1'b0; sp_we_q <= 1'b0; sp_addr_q <= '0; bias_load_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      bias_load_q <= 1'b0;
      case (state)
        S_IDLE: if (start_bit_i) begin
          mode_q <= mode_bit_i; wt_q <= write_target_i; rt_q <= read_target_i;
          n_q <= n_dim_i; k_q <= k_dim_i; m_q <= m_dim_i;
          busy_q <= 1'b1; op_valid_q <= 1'b1; op_k_q <= '0;
          state <= S_LOAD;
        end
        S_LOAD: if (bus.op_ready) begin
          if (op_k_q == k_q) begin
            op_valid_q <= 1'b0; op_k_q <= '0; drain_cnt <= '0;
            state <= S_DRAIN;
          end else begin
            op_k_q <= op_k_q + DIM_WIDTH'(1);
          end
        end
        S_DRAIN: if (drain_cnt == DRAIN_LAST) begin
          row_q <= '0; row_sel_q <= '0; sp_req_q <= 1'b1;
          sp_we_q   <= !mode_q;
          sp_addr_q <= mode_q ? {rt_q, ROW0} : {wt_q, ROW0};
          state     <= mode_q ? S_BIAS : S_WRITE;
        end else begin
          drain_cnt <= drain_cnt + DCW'(1);
        end
        S_BIAS: if (bus.sp_gnt) begin
          bias_load_q <= 1'b1;
          row_sel_q   <= row_q;
          if (row_q == n_q) begin
            // Request drops for the first WRITE cycle so row_sel_o can name the last bias row.
            sp_req_q <= 1'b0; sp_we_q <= 1'b1; sp_addr_q <= {wt_q, ROW0}; row_q <= '0;
            state <= S_WRITE;
          end else begin
            row_q <= row_nx; sp_addr_q <= {rt_q, row_nx};
          end
        end
        S_WRITE: if (!sp_req_q) begin
          sp_req_q <= 1'b1; row_sel_q <= '0;
        end else if (bus.sp_gnt) begin
          if (row_q == n_q) begin
            sp_req_q <= 1'b0; sp_we_q <= 1'b0; sp_addr_q <= '0;
            row_q <= '0; row_sel_q <= '0; done_q <= 1'b1;
            state <= S_DONE;
          end else begin
            row_q <= row_nx; row_sel_q <= row_nx; sp_addr_q <= {wt_q, row_nx};
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                             cycles_o <= '0;
    else if (accept)                       cycles_o <= '0;
    else if (busy_q && cycles_o != 16'hFFFF) cycles_o <= cycles_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: reset, plain run, bias run, PE/SP stalls,
// back-to-back restart and mid-run reset, with hand-derived cycle/address expectations.
module tb_matmul_sequencer;
  logic clk = 1'b0;
  logic rst, start, mode;
  logic [1:0] wt, rt, n, k, m;
  logic start_clear, busy, done;
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
  logic [15:0] cycles;
`endif
  int checks = 0, failures = 0;

  matmul_sequencer_if #(.DIM_WIDTH(2), .SP_AW(4)) bus ();

  matmul_sequencer #(.PE_LATENCY(2), .DIM_WIDTH(2), .SP_AW(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_bit_i(start), .mode_bit_i(mode),
    .write_target_i(wt), .read_target_i(rt), .n_dim_i(n), .k_dim_i(k), .m_dim_i(m),
    .start_clear_o(start_clear), .busy_o(busy), .done_o(done),
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    .cycles_o(cycles),
`endif
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  wire [17:0] outs = {start_clear, busy, done, bus.op_valid, bus.pe_clear, bus.sp_req, bus.sp_we,
                      bus.bias_load, bus.op_k, bus.sp_addr, bus.row_sel, bus.m_dim};

  typedef struct {int c; int v;} ev_t;
  ev_t beat_q[$], rd_q[$], wr_q[$], bl_q[$], sc_q[$], dn_q[$];
  int pc_c, m_seen, stall_bad;

  // Drives one run (two with nruns==2 and start held) and logs events by cycle; cycle 0 = start applied.
  task automatic run(input logic md, input logic [1:0] w, r, nn, kk, mm,
                     input int rdy_k, input int gnt_row, input int slen, input int nruns);
    int c, dones, rs, gs;
    bit rs_used, gs_used;
    logic [1:0] hk;
    logic [3:0] ha;
    beat_q.delete(); rd_q.delete(); wr_q.delete(); bl_q.delete(); sc_q.delete(); dn_q.delete();
    pc_c = -1; m_seen = -1; stall_bad = 0;
    c = 0; dones = 0; rs = 0; gs = 0; rs_used = 0; gs_used = 0; hk = 0; ha = 0;
    mode = md; wt = w; rt = r; n = nn; k = kk; m = mm;
    @(posedge clk); #1;
    while (dones < nruns && c < 300) begin
      start = (c == 0) || (nruns == 2 && sc_q.size() < 2);
      if (nruns == 2 && c == 1) begin wt = 2'd3; n = 2'd0; k = 2'd0; mode = 1'b0; end
      if (rdy_k >= 0 && !rs_used && bus.op_valid && int'(bus.op_k) == rdy_k) begin
        rs = slen; rs_used = 1; hk = bus.op_k;
      end
      bus.op_ready = (rs == 0);
      if (gnt_row >= 0 && !gs_used && bus.sp_req && bus.sp_we && int'(bus.sp_addr[1:0]) == gnt_row) begin
        gs = slen; gs_used = 1; ha = bus.sp_addr;
      end
      bus.sp_gnt = (gs == 0);
      #1;
      if (rs > 0) begin if (!bus.op_valid || bus.op_k !== hk) stall_bad++; rs--; end
      if (gs > 0) begin if (!bus.sp_req || !bus.sp_we || bus.sp_addr !== ha) stall_bad++; gs--; end
      if (start_clear) sc_q.push_back('{c, 0});
      if (bus.pe_clear && pc_c < 0) pc_c = c;
      if (c == 1) m_seen = int'(bus.m_dim);
      if (bus.op_valid && bus.op_ready) beat_q.push_back('{c, int'(bus.op_k)});
      if (bus.sp_req && bus.sp_gnt && !bus.sp_we) rd_q.push_back('{c, int'(bus.sp_addr)});
      if (bus.sp_req && bus.sp_gnt && bus.sp_we) wr_q.push_back('{c, int'(bus.sp_addr)});
      if (bus.bias_load) bl_q.push_back('{c, int'(bus.row_sel)});
      if (done) begin dn_q.push_back('{c, 0}); dones++; end
      c++;
      @(posedge clk); #1;
    end
    start = 0; bus.op_ready = 1; bus.sp_gnt = 1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; rst = 1; start = 1; #1;
      checks++;
      if (outs !== 18'd0) begin failures++; $display("FAIL reset_outs cyc%0d got=%h exp=0", i, outs); end
    end
    @(posedge clk); #1; rst = 0; start = 0; #1;
    checks++;
    if (outs !== 18'd0 || busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept got=%h exp=0", outs); end
  endtask

  task automatic test_basic();
    int gc, gv;
    run(0, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, -1, -1, 0, 1);
    gc = (sc_q.size() == 1) ? sc_q[0].c : -1;
    checks++; if (gc !== 0) begin failures++; $display("FAIL basic_start_clear got=%0d exp=0", gc); end
    checks++; if (pc_c !== 0) begin failures++; $display("FAIL basic_pe_clear got=%0d exp=0", pc_c); end
    checks++; if (m_seen !== 3) begin failures++; $display("FAIL basic_m_dim got=%0d exp=3", m_seen); end
    for (int i = 0; i < 4; i++) begin
      gc = (i < beat_q.size()) ? beat_q[i].c : -1; gv = (i < beat_q.size()) ? beat_q[i].v : -1;
      checks++;
      if (gc !== 1 + i || gv !== i) begin failures++; $display("FAIL basic_beat%0d got=c%0d/k%0d exp=c%0d/k%0d", i, gc, gv, 1 + i, i); end
    end
    for (int i = 0; i < 4; i++) begin
      gc = (i < wr_q.size()) ? wr_q[i].c : -1; gv = (i < wr_q.size()) ? wr_q[i].v : -1;
      checks++;
      if (gc !== 7 + i || gv !== 4 + i) begin failures++; $display("FAIL basic_write%0d got=c%0d/a%0d exp=c%0d/a%0d", i, gc, gv, 7 + i, 4 + i); end
    end
    checks++; if (rd_q.size() + bl_q.size() != 0) begin failures++; $display("FAIL basic_no_reads got=%0d exp=0", rd_q.size() + bl_q.size()); end
    gc = (dn_q.size() == 1) ? dn_q[0].c : -1;
    checks++; if (gc !== 11) begin failures++; $display("FAIL basic_done got=%0d exp=11", gc); end
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    @(posedge clk); #1; @(posedge clk); #2;
    checks++; if (cycles !== 16'd11) begin failures++; $display("FAIL basic_cycles got=%0d exp=11", cycles); end
`endif
  endtask

  task automatic test_bias();
    int exp_rd [2] = '{4, 5};
    int exp_ra [2] = '{8, 9};
    int exp_bl [2] = '{5, 6};
    int exp_wc [2] = '{7, 8};
    int exp_wa [2] = '{12, 13};
    int gc, gv;
    run(1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, -1, -1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      gc = (i < rd_q.size()) ? rd_q[i].c : -1; gv = (i < rd_q.size()) ? rd_q[i].v : -1;
      checks++;
      if (gc !== exp_rd[i] || gv !== exp_ra[i]) begin failures++; $display("FAIL bias_read%0d got=c%0d/a%0d exp=c%0d/a%0d", i, gc, gv, exp_rd[i], exp_ra[i]); end
      gc = (i < bl_q.size()) ? bl_q[i].c : -1; gv = (i < bl_q.size()) ? bl_q[i].v : -1;
      checks++;
      if (gc !== exp_bl[i] || gv !== i) begin failures++; $display("FAIL bias_load%0d got=c%0d/r%0d exp=c%0d/r%0d", i, gc, gv, exp_bl[i], i); end
      gc = (i < wr_q.size()) ? wr_q[i].c : -1; gv = (i < wr_q.size()) ? wr_q[i].v : -1;
      checks++;
      if (gc !== exp_wc[i] || gv !== exp_wa[i]) begin failures++; $display("FAIL bias_write%0d got=c%0d/a%0d exp=c%0d/a%0d", i, gc, gv, exp_wc[i], exp_wa[i]); end
    end
    gc = (dn_q.size() == 1) ? dn_q[0].c : -1;
    checks++; if (gc !== 9) begin failures++; $display("FAIL bias_done got=%0d exp=9", gc); end
  endtask

  task automatic test_ready_stall();
    int gc;
    run(0, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, 1, -1, 3, 1);
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL rdy_stall_hold got=%0d exp=0", stall_bad); end
    gc = (beat_q.size() == 4) ? beat_q[1].c * 10 + beat_q[1].v : -1;
    checks++; if (gc !== 51) begin failures++; $display("FAIL rdy_stall_k1 got=%0d exp=51", gc); end
    gc = (dn_q.size() == 1) ? dn_q[0].c : -1;
    checks++; if (gc !== 14) begin failures++; $display("FAIL rdy_stall_done got=%0d exp=14", gc); end
  endtask

  task automatic test_gnt_stall();
    int gc;
    run(0, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, -1, 2, 5, 1);
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL gnt_stall_hold got=%0d exp=0", stall_bad); end
    gc = (wr_q.size() == 4) ? wr_q[2].c * 100 + wr_q[2].v : -1;
    checks++; if (gc !== 1406) begin failures++; $display("FAIL gnt_stall_row2 got=%0d exp=1406", gc); end
    gc = (dn_q.size() == 1) ? dn_q[0].c : -1;
    checks++; if (gc !== 16) begin failures++; $display("FAIL gnt_stall_done got=%0d exp=16", gc); end
`ifdef MATMUL_SEQ_CYCLE_CNT_EN
    @(posedge clk); #2;
    checks++; if (cycles !== 16'd16) begin failures++; $display("FAIL gnt_stall_cycles got=%0d exp=16", cycles); end
`endif
  endtask

  task automatic test_back_to_back();
    int gc, gv;
    run(0, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, -1, -1, 0, 2);
    gc = (sc_q.size() == 2) ? sc_q[1].c : -1;
    checks++; if (gc !== 12) begin failures++; $display("FAIL b2b_second_accept got=%0d exp=12", gc); end
    gv = (wr_q.size() == 5) ? wr_q[3].v * 100 + wr_q[4].v : -1;
    checks++; if (gv !== 712) begin failures++; $display("FAIL b2b_snapshot got=%0d exp=712", gv); end
    gc = (dn_q.size() == 2) ? dn_q[0].c * 100 + dn_q[1].c : -1;
    checks++; if (gc !== 1117) begin failures++; $display("FAIL b2b_done got=%0d exp=1117", gc); end
  endtask

  task automatic test_reset_midrun();
    int c, seen, gc;
    mode = 0; wt = 2'd1; rt = 0; n = 2'd3; k = 2'd3; m = 2'd3;
    @(posedge clk); #1; start = 1;
    c = 0;
    while (!(bus.op_valid && bus.op_k == 2'd2) && c < 20) begin
      @(posedge clk); #1; start = 0; c++;
    end
    checks++; if (c >= 20) begin failures++; $display("FAIL midrst_reach_k2 got=timeout exp=k2"); end
    rst = 1;
    @(posedge clk); #1; rst = 0; #1;
    checks++; if (outs !== 18'd0) begin failures++; $display("FAIL midrst_idle got=%h exp=0", outs); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin @(posedge clk); #2; if (done || busy) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    run(0, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, -1, -1, 0, 1);
    gc = (beat_q.size() == 4) ? beat_q[0].c * 10 + beat_q[0].v : -1;
    checks++; if (gc !== 10) begin failures++; $display("FAIL midrst_fresh_k0 got=%0d exp=10", gc); end
    gc = (dn_q.size() == 1) ? dn_q[0].c : -1;
    checks++; if (gc !== 11) begin failures++; $display("FAIL midrst_fresh_done got=%0d exp=11", gc); end
  endtask

  initial begin
    rst = 1; start = 1; mode = 0; wt = 0; rt = 0; n = 0; k = 0; m = 0;
    bus.op_ready = 1; bus.sp_gnt = 1;
    test_reset();
    test_basic();
    test_bias();
    test_ready_stall();
    test_gnt_stall();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
